or1k_tt_alarm_sched: RTL and testbench

//  Multiplexes NUM_SLOTS software alarm slots onto the single tick timer: tracks absolute 28-bit deadlines.

---
 rtl/or1k_tt_alarm_sched.sv | 160 ++++++++++++++++
 tb/tb_or1k_tt_alarm_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or1k_tt_alarm_sched.sv
// Alarm scheduler: multiplexes NUM_SLOTS software alarms onto the single tick timer by
// keeping TTMR programmed with the nearest armed deadline and sweeping slots on each IP.
// Ports: cfg_* slot ARM/DISARM command (valid/ready); pend_clr_i/irq_en_i pending control;
//        ttcr_i/ttmr_i live timer state; spr_* TTMR write master; armed_o/pending_o/irq_o status.
module or1k_tt_alarm_sched #(
  parameter int          NUM_SLOTS = 4,
  parameter int          LEAD      = 8,
  parameter logic [15:0] TTMR_ADDR = 16'h5000,
  localparam int         SW        = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 cfg_op_i,
  input  logic [SW-1:0]        cfg_slot_i,
  input  logic [27:0]          cfg_deadline_i,
  input  logic [NUM_SLOTS-1:0] pend_clr_i,
  input  logic [NUM_SLOTS-1:0] irq_en_i,
  input  logic [31:0]          ttcr_i,
  input  logic [31:0]          ttmr_i,
  output logic                 spr_access_o,
  output logic                 spr_we_o,
  output logic [15:0]          spr_addr_o,
  output logic [31:0]          spr_dat_o,
  input  logic                 spr_ack_i,
  output logic [NUM_SLOTS-1:0] armed_o,
  output logic [NUM_SLOTS-1:0] pending_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {IDLE, SCAN, PROG} state_t;

  state_t               state, state_n;
  logic [27:0]          dl [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] armed, armed_n, pending, pend_set;
  logic                 irq, dirty, prog_valid;
  logic [31:0]          spr_dat, prog_word;
  logic [SW-1:0]        idx;
  logic                 best_vld;
  logic [27:0]          best_rem, best_dl;

  logic        accept, last, expire, cand, fin_vld, need_prog, go_prog, poll;
  logic [27:0] cur_dl, cur_rem, fin_rem, fin_dl;
  logic        cur_due;
  logic        unused_bits;

  assign unused_bits = ^{ttcr_i[31:28], ttmr_i[31:29]};

  assign accept  = cfg_valid_i & cfg_ready_o;
  assign cur_dl  = dl[idx];
  assign cur_rem = cur_dl - ttcr_i[27:0];
  // Distances in the upper half of the 28-bit range mean the deadline has passed.
  assign cur_due = (cur_rem == 28'd0) | cur_rem[27];
  assign last    = (idx == SW'(NUM_SLOTS - 1));
  assign expire  = (state == SCAN) & armed[idx] & cur_due;
  // Strict compare: on a tie the lower index already held stays best.
  assign cand    = (state == SCAN) & armed[idx] & ~cur_due & (~best_vld | (cur_rem < best_rem));

  // The slot inspected on the final scan cycle participates in the final decision.
  assign fin_vld   = cand | best_vld;
  assign fin_rem   = cand ? cur_rem : best_rem;
  assign fin_dl    = cand ? cur_dl  : best_dl;
  assign need_prog = ~prog_valid | (ttmr_i[27:0] != fin_dl) | ttmr_i[28];

  always_comb begin
    state_n   = state;
    go_prog   = 1'b0;
    prog_word = 32'h0;
    poll      = 1'b0;
    case (state)
      IDLE: if (dirty) state_n = SCAN;
      SCAN: begin
        if (!accept && last) begin
          if (fin_vld) begin
            if (fin_rem <= 28'(LEAD)) begin
              // Too close to program safely; rescan until it expires.
              poll    = 1'b1;
              state_n = IDLE;
            end else if (need_prog) begin
              go_prog   = 1'b1;
              prog_word = {2'b11, 1'b1, 1'b0, fin_dl};
              state_n   = PROG;
            end else begin
              state_n = IDLE;
            end
          end else if (prog_valid) begin
            go_prog = 1'b1;
            state_n = PROG;
          end else begin
            state_n = IDLE;
          end
        end
      end
      PROG: if (spr_ack_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    armed_n  = armed;
    pend_set = '0;
    if (expire) begin
      armed_n[idx]  = 1'b0;
      pend_set[idx] = 1'b1;
    end
    // A command to the slot overrides its expiry; the pending bit still records it.
    if (accept) armed_n[cfg_slot_i] = cfg_op_i;
  end

  always_ff @(posedge clk) begin
    if (accept && cfg_op_i) dl[cfg_slot_i] <= cfg_deadline_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      armed      <= '0;
      pending    <= '0;
      irq        <= 1'b0;
      dirty      <= 1'b1;
      prog_valid <= 1'b0;
      spr_dat    <= 32'h0;
      idx        <= '0;
      best_vld   <= 1'b0;
      best_rem   <= '0;
      best_dl    <= '0;
    end else begin
      state   <= state_n;
      armed   <= armed_n;
      pending <= (pending & ~pend_clr_i) | pend_set;
      irq     <= |(pending & irq_en_i);
      dirty   <= accept | poll | ((state == IDLE) & prog_valid & ttmr_i[28]) |
                 (dirty & ~(state == IDLE));
      if ((state == IDLE && dirty) || (state == SCAN && accept)) begin
        idx      <= '0;
        best_vld <= 1'b0;
      end else if (state == SCAN) begin
        idx <= idx + 1'b1;
        if (cand) begin
          best_vld <= 1'b1;
          best_rem <= cur_rem;
          best_dl  <= cur_dl;
        end
      end
      if (go_prog) spr_dat <= prog_word;
      if (state == PROG && spr_ack_i) prog_valid <= (spr_dat != 32'h0);
    end
  end

  assign cfg_ready_o  = (state != PROG);
  assign spr_access_o = (state == PROG);
  assign spr_we_o     = (state == PROG);
  assign spr_addr_o   = TTMR_ADDR;
  assign spr_dat_o    = spr_dat;
  assign armed_o      = armed;
  assign pending_o    = pending;
  assign irq_o        = irq;

endmodule

// File: tb/tb_or1k_tt_alarm_sched.sv
// Bench for or1k_tt_alarm_sched: a tick-timer model (free-running TTCR, TTMR with IP on match)
// answers the SPR writes; a slot-level model (deadlines, wrap-aware due test) predicts expiries,
// the nearest programmed deadline, pending and irq.
module tb_or1k_tt_alarm_sched;
  localparam int N     = 4;
  localparam int LEAD  = 8;
  localparam int BOUND = 2 * N + 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, cfg_op;
  logic [1:0]  cfg_slot;
  logic [27:0] cfg_deadline;
  logic [3:0]  pend_clr, irq_en, armed, pending;
  logic [31:0] ttcr = '0;
  logic [31:0] ttmr = '0;
  logic        spr_access, spr_we, spr_ack, irq;
  logic [15:0] spr_addr;
  logic [31:0] spr_dat;
  logic        ack_en, ttcr_load;
  logic [31:0] ttcr_val;
  int          wr_cnt = 0;
  logic [31:0] wr_last = '0;
  logic [15:0] wr_addr = '0;
  logic        wr_we = 1'b0;

  int checks = 0;
  int failures = 0;

  bit          m_armed [N];
  logic [27:0] m_dl [N];
  bit          m_pend [N];
  int          age [N];
  logic [3:0]  prev_pend;

  or1k_tt_alarm_sched #(.NUM_SLOTS(N), .LEAD(LEAD), .TTMR_ADDR(16'h5000)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_op_i(cfg_op),
    .cfg_slot_i(cfg_slot), .cfg_deadline_i(cfg_deadline),
    .pend_clr_i(pend_clr), .irq_en_i(irq_en),
    .ttcr_i(ttcr), .ttmr_i(ttmr),
    .spr_access_o(spr_access), .spr_we_o(spr_we), .spr_addr_o(spr_addr),
    .spr_dat_o(spr_dat), .spr_ack_i(spr_ack),
    .armed_o(armed), .pending_o(pending), .irq_o(irq)
  );

  always #5 clk = ~clk;

  assign spr_ack = spr_access & ack_en;

  // Tick timer: continuous-mode counter, IP raised when TTCR matches TTMR with IE set.
  always @(posedge clk) begin
    ttcr <= ttcr_load ? ttcr_val : ttcr + 32'd1;
    if (rst) begin
      ttmr <= '0;
    end else if (spr_access && spr_ack) begin
      ttmr    <= spr_dat;
      wr_cnt  <= wr_cnt + 1;
      wr_last <= spr_dat;
      wr_addr <= spr_addr;
      wr_we   <= spr_we;
    end else if (ttmr[29] && ttmr[31:30] != 2'b00 && ttcr[27:0] == ttmr[27:0]) begin
      ttmr[28] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit due(input logic [27:0] d, input logic [27:0] t);
    logic [27:0] r;
    r = d - t;
    return (r == 28'd0) || r[27];
  endfunction

  function automatic logic [3:0] armed_mask();
    logic [3:0] m;
    for (int k = 0; k < N; k++) m[k] = m_armed[k];
    return m;
  endfunction

  function automatic logic [3:0] pend_mask();
    logic [3:0] m;
    for (int k = 0; k < N; k++) m[k] = m_pend[k];
    return m;
  endfunction

  task automatic monitor();
    for (int k = 0; k < N; k++) begin
      if (pending[k] && !prev_pend[k]) begin
        chk($sformatf("pend_rise_due%0d", k),
            32'(m_armed[k] && due(m_dl[k], ttcr[27:0])), 32'd1);
        m_armed[k] = 1'b0;
        m_pend[k]  = 1'b1;
        age[k]     = 0;
      end
      if (m_armed[k] && due(m_dl[k], ttcr[27:0])) begin
        age[k]++;
        if (age[k] > BOUND) begin
          chk($sformatf("expiry_late%0d", k), 32'(pending[k]), 32'd1);
          m_armed[k] = 1'b0;
        end
      end
    end
    prev_pend = pending;
    chk("armed_track", 32'(armed), 32'(armed_mask()));
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg(input bit op, input int slot, input logic [27:0] d);
    int n = 0;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid    = 1'b1;
    cfg_op       = op;
    cfg_slot     = 2'(slot);
    cfg_deadline = d;
    @(negedge clk);
    m_armed[slot] = op;
    if (op) m_dl[slot] = d;
    age[slot] = 0;
    cfg_valid = 1'b0;
    monitor();
  endtask

  task automatic clear_pend();
    pend_clr = 4'hF;
    tick();
    pend_clr = 4'h0;
    for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
  endtask

  task automatic ttcr_set(input logic [31:0] v);
    ttcr_load = 1'b1;
    ttcr_val  = v;
    tick();
    ttcr_load = 1'b0;
  endtask

  initial begin
    int          w0, n, lat, pick;
    logic [27:0] d;
    logic [27:0] best_rem, r;
    logic [31:0] exp_ttmr;
    bit          any;

    rst = 1'b1; cfg_valid = 1'b0; cfg_op = 1'b0; cfg_slot = '0; cfg_deadline = '0;
    pend_clr = '0; irq_en = '0; ack_en = 1'b1; ttcr_load = 1'b1; ttcr_val = '0;
    prev_pend = '0;
    for (int k = 0; k < N; k++) begin
      m_armed[k] = 1'b0; m_dl[k] = '0; m_pend[k] = 1'b0; age[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_access", 32'(spr_access), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_dat", spr_dat, 32'd0);
    rst = 1'b0;
    ttcr_load = 1'b0;
    run(10);

    // Single programmed alarm
    irq_en = 4'b0001;
    w0 = wr_cnt;
    cfg(1'b1, 0, 28'd100);
    run(10);
    chk("t1_wr_count", 32'(wr_cnt - w0), 32'd1);
    chk("t1_ttmr", wr_last, 32'hE000_0064);
    chk("t1_addr", 32'(wr_addr), 32'h5000);
    chk("t1_we", 32'(wr_we), 32'd1);
    run(110);
    chk("t1_pending", 32'(pending), 32'b0001);
    chk("t1_disable", wr_last, 32'h0);
    chk("t1_wr_count2", 32'(wr_cnt - w0), 32'd2);
    chk("t1_irq", 32'(irq), 32'd1);
    clear_pend();
    run(2);
    chk("t1_irq_clr", 32'(irq), 32'd0);

    // Nearest deadline first, tie on 200
    ttcr_set(32'd0);
    cfg(1'b1, 0, 28'd500);
    cfg(1'b1, 1, 28'd200);
    cfg(1'b1, 2, 28'd200);
    run(12);
    chk("t2_first", ttmr, 32'hE000_00C8);
    n = 230 - int'(ttcr[27:0]);
    run(n);
    chk("t2_pend_mid", 32'(pending), 32'b0110);
    chk("t2_reprog", ttmr, 32'hE000_01F4);
    run(300);
    chk("t2_pend_end", 32'(pending), 32'b0111);
    chk("t2_ttmr_end", ttmr, 32'h0);
    clear_pend();

    // Deadline inside LEAD: polled, never programmed
    w0 = wr_cnt;
    d = ttcr[27:0] + 28'd3;
    cfg(1'b1, 3, d);
    n = 0;
    while (!pending[3] && n < 30) begin
      tick();
      n++;
    end
    lat = int'(ttcr[27:0] - d);
    chk("t3_seen", 32'(pending[3]), 32'd1);
    chk("t3_latency", 32'(lat <= 3 + N + 2 + 1), 32'd1);
    chk("t3_no_write", 32'(wr_cnt - w0), 32'd0);
    clear_pend();

    // Counter wrap
    ttcr_set(32'h0FFF_FFF0);
    cfg(1'b1, 0, 28'h10);
    run(10);
    chk("t4_prog", wr_last, 32'hE000_0010);
    chk("t4_armed", 32'(armed), 32'b0001);
    chk("t4_not_due", 32'(pending), 32'd0);
    run(60);
    chk("t4_pending", 32'(pending), 32'b0001);
    chk("t4_disable", wr_last, 32'h0);
    clear_pend();

    // Disarm before expiry
    w0 = wr_cnt;
    d = ttcr[27:0] + 28'd100;
    cfg(1'b1, 1, d);
    run(10);
    chk("t5_prog", wr_last, {4'hE, d});
    cfg(1'b0, 1, 28'd0);
    run(10);
    chk("t5_disable", wr_last, 32'h0);
    chk("t5_wr_count", 32'(wr_cnt - w0), 32'd2);
    run(120);
    chk("t5_pending", 32'(pending), 32'd0);

    // Stalled ack, then reset in PROG
    ack_en = 1'b0;
    w0 = wr_cnt;
    d = ttcr[27:0] + 28'd200;
    cfg(1'b1, 2, d);
    n = 0;
    while (!spr_access && n < 20) begin
      tick();
      n++;
    end
    chk("t6_access", 32'(spr_access), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold_access", 32'(spr_access), 32'd1);
      chk("t6_hold_addr", 32'(spr_addr), 32'h5000);
      chk("t6_hold_dat", spr_dat, {4'hE, d});
      chk("t6_hold_ready", 32'(cfg_ready), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      m_armed[k] = 1'b0; m_pend[k] = 1'b0; age[k] = 0;
    end
    chk("t6_rst_access", 32'(spr_access), 32'd0);
    chk("t6_rst_dat", spr_dat, 32'd0);
    chk("t6_rst_armed", 32'(armed), 32'd0);
    chk("t6_rst_ready", 32'(cfg_ready), 32'd1);
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_no_write", 32'(wr_cnt - w0), 32'd0);
    rst = 1'b0;
    ack_en = 1'b1;
    prev_pend = pending;
    run(5);

    // Randomized rounds against the slot model
    for (int rnd = 0; rnd < 6; rnd++) begin
      irq_en = 4'($urandom);
      for (int k = 0; k < N; k++)
        if ($urandom_range(3) != 0)
          cfg(1'b1, k, ttcr[27:0] + 28'(80 + $urandom_range(299)));
      if ($urandom_range(1) == 1) begin
        pick = -1;
        for (int k = 0; k < N; k++) if (m_armed[k] && pick < 0) pick = k;
        if (pick >= 0) cfg(1'b0, pick, 28'd0);
      end
      run(12);
      any = 1'b0;
      best_rem = '1;
      exp_ttmr = 32'h0;
      for (int k = 0; k < N; k++) begin
        r = m_dl[k] - ttcr[27:0];
        if (m_armed[k] && (!any || r < best_rem)) begin
          any = 1'b1;
          best_rem = r;
          exp_ttmr = {4'hE, m_dl[k]};
        end
      end
      chk("rnd_ttmr", ttmr, exp_ttmr);
      run(420);
      chk("rnd_pending", 32'(pending), 32'(pend_mask()));
      chk("rnd_armed", 32'(armed), 32'd0);
      chk("rnd_ttmr_end", ttmr, 32'h0);
      chk("rnd_irq", 32'(irq), 32'(|(pend_mask() & irq_en)));
      clear_pend();
      run(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
